mul_arbiter: RTL and testbench

Shares one `mul` multiplier instance (W×W→2W, start/busy handshake) between N_REQ requesting engines, such as the cube-root and square-root sequencers. It arbitrates between requesters, registers the winner's operands into the multiplier, and sequences the start/busy exchange. It returns the product with a per-requester one-cycle done pulse. It sits between the arithmetic engines and a single `mul`, replacing per-engine multiplier copies.

---
 rtl/mul_arb_pkg.sv | 21 ++
 rtl/mul_arbiter_rr_pick.sv | 48 ++++
 rtl/mul_arbiter.sv | 130 +++++++++++++
 tb/tb_mul_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier arbiter.
// Optional build macro: MUL_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package mul_arb_pkg;

    localparam int MUL_ARB_N_REQ = 2;
    localparam int MUL_ARB_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MUL_ARB_IDX_W = idx_w(MUL_ARB_N_REQ);

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational requester pick: round-robin after last_i, or lowest index
// when MUL_ARB_FIXED_PRIO_EN is defined.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int N_REQ = MUL_ARB_N_REQ,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

`ifdef MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        // Descending scan so the lowest asserted index is the last write.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
    end
`else
    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last_i) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/mul_arbiter.sv
// Shares one start/busy multiplier between N_REQ requesters.
// Optional build macro: MUL_ARB_FIXED_PRIO_EN (fixed priority, no last_gnt).
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ = MUL_ARB_N_REQ,
    parameter int W     = MUL_ARB_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*W-1:0] a_bi,
    input  logic [N_REQ*W-1:0] b_bi,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [2*W-1:0]     y_bo,
    output logic               busy_o,
    output logic [W-1:0]       mul_a_bo,
    output logic [W-1:0]       mul_b_bo,
    output logic               mul_start_o,
    input  logic               mul_busy_i,
    input  logic [2*W-1:0]     mul_y_bi
);

    localparam int IW = idx_w(N_REQ);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [2*W-1:0]   y_q, y_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [IW-1:0]    last_q, last_d;
    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;

    rr_pick #(
        .N_REQ(N_REQ),
        .IW   (IW)
    ) u_pick (
        .req_i (req_i),
        .last_i(last_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        y_d     = y_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_ISSUE;
                    gnt_d   = pick_gnt;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    a_d     = a_bi[pick_idx*W +: W];
                    b_d     = b_bi[pick_idx*W +: W];
                    last_d  = pick_idx;
                end
            end
            ST_ISSUE: state_d = ST_RUN;
            ST_RUN: begin
                if (!mul_busy_i) begin
                    state_d = ST_DONE;
                    y_d     = mul_y_bi;
                    done_d  = gnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef MUL_ARB_FIXED_PRIO_EN
    assign last_q = '0;
`else
    // Reset to the top index so requester 0 is searched first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= IW'(N_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign y_bo        = y_q;
    assign busy_o      = busy_q;
    assign mul_start_o = start_q;
    assign mul_a_bo    = a_q;
    assign mul_b_bo    = b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural start/busy multiplier.
module tb_mul_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [15:0] y;
    logic        busy;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic        m_start;
    logic        m_busy;
    logic [15:0] m_y;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 8;

    mul_arbiter #(.N_REQ(2), .W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .req_i      (req),
        .a_bi       (a_bus),
        .b_bi       (b_bus),
        .gnt_o      (gnt),
        .done_o     (done),
        .y_bo       (y),
        .busy_o     (busy),
        .mul_a_bo   (m_a),
        .mul_b_bo   (m_b),
        .mul_start_o(m_start),
        .mul_busy_i (m_busy),
        .mul_y_bi   (m_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: RUN lasts lat cycles (busy high lat-1 cycles).
    logic [7:0] cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            m_y <= '0;
        end else if (m_start) begin
            cnt <= 8'(lat - 1);
            m_y <= m_a * m_b;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign m_busy = (cnt != 0);

    typedef struct {
        logic [1:0]  rq;
        logic [7:0]  a0, b0, a1, b1;
        int          l;
        logic [1:0]  eg;
        logic [15:0] ey;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Call in an IDLE cycle after inputs are applied; act 1 = change
    // operands during RUN, act 2 = drop req during RUN.
    task automatic run_op(input string nm, input logic [1:0] eg,
                          input logic [15:0] ey, input logic [7:0] ea,
                          input logic [7:0] eb, input int act);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
                chk({nm, ".start"}, 32'(m_start), 1);
                chk({nm, ".busy"}, 32'(busy), 1);
                chk({nm, ".mul_a"}, 32'(m_a), 32'(ea));
                chk({nm, ".mul_b"}, 32'(m_b), 32'(eb));
            end
            if (n == 2) chk({nm, ".start1cyc"}, 32'(m_start), 0);
            if (n == 3 && act == 1) begin
                a_bus = 16'hFFFF;
                b_bus = 16'hFFFF;
            end
            if (n == 3 && act == 2) req = 2'b00;
            if (done != 0) seen = 1;
        end
        if (!seen) begin
            chk({nm, ".timeout"}, 0, 1);
            return;
        end
        chk({nm, ".latency"}, 32'(n), 32'(lat + 2));
        chk({nm, ".done"}, 32'(done), 32'(eg));
        chk({nm, ".y"}, 32'(y), 32'(ey));
        chk({nm, ".hold_a"}, 32'(m_a), 32'(ea));
        @(negedge clk);
        chk({nm, ".idle_busy"}, 32'(busy), 0);
        chk({nm, ".idle_gnt"}, 32'(gnt), 0);
        chk({nm, ".done_1cyc"}, 32'(done), 0);
        chk({nm, ".y_held"}, 32'(y), 32'(ey));
    endtask

    task automatic apply(input vec_t v);
        req   = v.rq;
        a_bus = {v.a1, v.a0};
        b_bus = {v.b1, v.b0};
        lat   = v.l;
    endtask

    initial begin
        vt[0] = '{2'b01, 8'd3, 8'd5, 8'd0, 8'd0, 8, 2'b01, 16'd15};
`ifdef MUL_ARB_FIXED_PRIO_EN
        vt[1] = '{2'b11, 8'd7, 8'd9, 8'd255, 8'd255, 8, 2'b01, 16'd63};
        vt[2] = '{2'b11, 8'd7, 8'd9, 8'd255, 8'd255, 8, 2'b01, 16'd63};
        vt[3] = '{2'b11, 8'd7, 8'd9, 8'd255, 8'd255, 8, 2'b01, 16'd63};
        vt[4] = '{2'b11, 8'd7, 8'd9, 8'd255, 8'd255, 4, 2'b01, 16'd63};
`else
        vt[1] = '{2'b11, 8'd7, 8'd9, 8'd255, 8'd255, 8, 2'b10, 16'd65025};
        vt[2] = '{2'b11, 8'd7, 8'd9, 8'd255, 8'd255, 8, 2'b01, 16'd63};
        vt[3] = '{2'b11, 8'd7, 8'd9, 8'd255, 8'd255, 8, 2'b10, 16'd65025};
        vt[4] = '{2'b11, 8'd7, 8'd9, 8'd255, 8'd255, 4, 2'b01, 16'd63};
`endif
        vt[5] = '{2'b10, 8'd1, 8'd1, 8'd16, 8'd16, 2, 2'b10, 16'd256};
        vt[6] = '{2'b10, 8'd1, 8'd1, 8'd0, 8'd200, 3, 2'b10, 16'd0};
        vt[7] = '{2'b01, 8'd255, 8'd1, 8'd9, 8'd9, 8, 2'b01, 16'd255};

        rst_n = 1'b0;
        req   = '0;
        a_bus = '0;
        b_bus = '0;
        repeat (3) @(negedge clk);
        chk("rst.gnt", 32'(gnt), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.y", 32'(y), 0);
        chk("rst.start", 32'(m_start), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            apply(vt[i]);
            run_op($sformatf("vec%0d", i), vt[i].eg, vt[i].ey,
                   vt[i].eg[0] ? vt[i].a0 : vt[i].a1,
                   vt[i].eg[0] ? vt[i].b0 : vt[i].b1, 0);
        end

        apply('{2'b01, 8'd20, 8'd10, 8'd0, 8'd0, 8, 2'b01, 16'd200});
        run_op("stable", 2'b01, 16'd200, 8'd20, 8'd10, 1);

        apply('{2'b10, 8'd0, 8'd0, 8'd12, 8'd12, 8, 2'b10, 16'd144});
        run_op("drop", 2'b10, 16'd144, 8'd12, 8'd12, 2);
        repeat (4) @(negedge clk);
        chk("drop.no_regrant", 32'(gnt), 0);
        chk("drop.idle", 32'(busy), 0);

        apply('{2'b01, 8'd4, 8'd4, 8'd5, 8'd5, 8, 2'b01, 16'd16});
        repeat (4) @(negedge clk);
        chk("rstmid.inrun", 32'(busy), 1);
        req   = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("rstmid.gnt", 32'(gnt), 0);
        chk("rstmid.done", 32'(done), 0);
        chk("rstmid.y", 32'(y), 0);
        chk("rstmid.busy", 32'(busy), 0);
        chk("rstmid.start", 32'(m_start), 0);
        chk("rstmid.mul_ab", 32'({m_a, m_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("rstmid.next", 2'b01, 16'd16, 8'd4, 8'd4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
